// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter: two-port round-robin arbiter for one req/ack memory.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output logic              grant,
  output logic              busy
);

  localparam logic [0:0]    S_IDLE = 1'b0;
  localparam logic [0:0]    S_BUSY = 1'b1;
  localparam logic [CW-1:0] c_last = CW'(TIMEOUT - 1);

  logic [0:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_bubble;

  logic              w_any;
  logic              w_pick;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_expired;
  logic              w_finish;

  // The cycle right after a completion never grants, so a requester still
  // holding req while it sees ack cannot be served twice.
  always_comb begin
    w_any       = (m0_req | m1_req) & ~r_bubble;
    w_pick      = (m0_req & m1_req) ? ~grant : m1_req;
    w_sel_we    = w_pick ? m1_we    : m0_we;
    w_sel_addr  = w_pick ? m1_addr  : m0_addr;
    w_sel_wdata = w_pick ? m1_wdata : m0_wdata;
    w_expired   = (r_cnt == c_last);
    w_finish    = mem_ack | w_expired;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bubble  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      grant     <= 1'b1;
    end else begin
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      err      <= 1'b0;
      r_bubble <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            grant     <= w_pick;
            mem_req   <= 1'b1;
            mem_we    <= w_sel_we;
            mem_addr  <= w_sel_addr;
            mem_wdata <= w_sel_wdata;
            busy      <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_finish) begin
            // mem_ack wins over the watchdog when both land together.
            if (grant) begin
              m1_rdata <= mem_ack ? mem_rdata : '0;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= mem_ack ? mem_rdata : '0;
              m0_ack   <= 1'b1;
            end
            err      <= ~mem_ack;
            mem_req  <= 1'b0;
            busy     <= 1'b0;
            r_bubble <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.              |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        err, grant, busy;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mem_lat = 1;       // 0 = memory never acks
  logic use_fixed = 1'b0;
  logic [31:0] fixed_data = 32'h0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CW(8)) dut (
    .clk(clk), .clr_n(clr_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err), .grant(grant), .busy(busy)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: ack during the mem_lat-th cycle that mem_req is high.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req && mem_lat != 0) begin
        if (cnt == mem_lat - 1) begin
          mem_ack   = 1'b1;
          mem_rdata = use_fixed ? fixed_data : mem_fn(mem_addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard: every ack pops one expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m0_ack && m1_ack) begin
        checks++; errors++;
        $display("FAIL dual_ack: m0_ack=%b m1_ack=%b required not both high", m0_ack, m1_ack);
      end else if (m0_ack || m1_ack) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: m0_ack=%b m1_ack=%b with empty scoreboard", m0_ack, m1_ack);
        end else begin
          e = q.pop_front();
          if (m1_ack !== e.port || err !== e.err ||
              (e.port ? m1_rdata : m0_rdata) !== e.rdata) begin
            errors++;
            $display("FAIL completion: port=%0d err=%b rdata=%h required port=%0d err=%b rdata=%h",
                     m1_ack, err, (m1_ack ? m1_rdata : m0_rdata), e.port, e.err, e.rdata);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, busy, err, m0_ack, m1_ack, grant} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_ctrl: req/we/busy/err/ack0/ack1/grant=%b required 0000001",
               {mem_req, mem_we, busy, err, m0_ack, m1_ack, grant});
    end
    checks++;
    if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rd0=%h rd1=%h required all 0",
               mem_addr, mem_wdata, m0_rdata, m1_rdata);
    end
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int n, hi;
    mem_lat = 2; use_fixed = 1'b1; fixed_data = 32'hDEADBEEF;
    q.push_back('{port: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || grant !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_issue: req=%b addr=%h we=%b grant=%b busy=%b required 1 00000100 0 0 1",
               mem_req, mem_addr, mem_we, grant, busy);
    end
    n = 0; hi = 1;
    do begin
      @(negedge clk); n++;
      if (mem_req) hi++;
    end while (!m0_ack && n < 20);
    m0_req = 1'b0;
    checks++;
    if (!m0_ack || hi != 2) begin
      errors++;
      $display("FAIL single_ack: m0_ack=%b mem_req_cycles=%0d required ack 1 after 2 cycles", m0_ack, hi);
    end
    use_fixed = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tie();
    int n;
    do_reset();
    mem_lat = 1;
    q.push_back('{port: 1'b0, rdata: mem_fn(32'h10), err: 1'b0});
    q.push_back('{port: 1'b1, rdata: mem_fn(32'h20), err: 1'b0});
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h55;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    @(negedge clk);
    checks++;
    if (grant !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'h55) begin
      errors++;
      $display("FAIL tie_first: grant=%b we=%b addr=%h wdata=%h required 0 1 00000010 00000055",
               grant, mem_we, mem_addr, mem_wdata);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!m0_ack && n < 20);
    m0_req = 1'b0;
    checks++;
    if (!m0_ack || busy !== 1'b0) begin
      errors++;
      $display("FAIL tie_ack0: m0_ack=%b busy=%b required 1 0", m0_ack, busy);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL tie_bubble: mem_req=%b required 0", mem_req);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || grant !== 1'b1 || mem_addr !== 32'h20) begin
      errors++;
      $display("FAIL tie_second: req=%b grant=%b addr=%h required 1 1 00000020", mem_req, grant, mem_addr);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!m1_ack && n < 20);
    m1_req = 1'b0;
    checks++;
    if (!m1_ack) begin
      errors++;
      $display("FAIL tie_ack1: m1_ack=%b required 1", m1_ack);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int n, t, last_t;
    mem_lat = 1; last_t = 0; t = 0;
    for (int i = 0; i < 6; i++)
      q.push_back('{port: 1'(i % 2), rdata: mem_fn((i % 2) ? 32'h300 : 32'h200), err: 1'b0});
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h200;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h300;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      do begin @(negedge clk); n++; t++; end while (!(m0_ack || m1_ack) && n < 20);
      checks++;
      if (!(m0_ack || m1_ack) || m1_ack !== 1'(i % 2)) begin
        errors++;
        $display("FAIL rr_order[%0d]: m0_ack=%b m1_ack=%b required port %0d", i, m0_ack, m1_ack, i % 2);
      end
      if (i > 0) begin
        checks++;
        if (t - last_t != 3) begin
          errors++;
          $display("FAIL rr_spacing[%0d]: %0d cycles required 3", i, t - last_t);
        end
      end
      last_t = t;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n, hi;
    mem_lat = 0;
    q.push_back('{port: 1'b1, rdata: 32'h0, err: 1'b1});
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
    n = 0; hi = 0;
    do begin
      @(negedge clk); n++;
      if (mem_req) hi++;
    end while (!m1_ack && n < 30);
    m1_req = 1'b0;
    checks++;
    if (!m1_ack || hi != 4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: m1_ack=%b mem_req_cycles=%0d busy=%b required 1 4 0", m1_ack, hi, busy);
    end
    mem_lat = 1;
    q.push_back('{port: 1'b0, rdata: mem_fn(32'h44), err: 1'b0});
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h44;
    n = 0;
    do begin @(negedge clk); n++; end while (!m0_ack && n < 20);
    m0_req = 1'b0;
    checks++;
    if (!m0_ack) begin
      errors++;
      $display("FAIL timeout_next: m0_ack=%b required 1", m0_ack);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop_req();
    int n, bad;
    mem_lat = 3; use_fixed = 1'b1; fixed_data = 32'h1234;
    q.push_back('{port: 1'b0, rdata: 32'h1234, err: 1'b0});
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h80;
    @(negedge clk);
    m0_req = 1'b0; m0_addr = 32'hFFFF; m0_we = 1'b1;
    n = 0; bad = 0;
    do begin
      if (busy && (mem_addr !== 32'h80 || mem_we !== 1'b0)) bad++;
      @(negedge clk); n++;
    end while (!m0_ack && n < 20);
    checks++;
    if (!m0_ack || bad != 0) begin
      errors++;
      $display("FAIL drop_req: m0_ack=%b unstable_cycles=%0d required 1 0", m0_ack, bad);
    end
    use_fixed = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    mem_lat = 0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hC0;
    repeat (2) @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || grant !== 1'b1 || busy !== 1'b0 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: req=%b grant=%b busy=%b ack=%b required 0 1 0 0", mem_req, grant, busy, m0_ack);
    end
    mem_lat = 2;
    q.push_back('{port: 1'b0, rdata: mem_fn(32'hC0), err: 1'b0});
    clr_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m0_ack && n < 20);
    m0_req = 1'b0;
    checks++;
    if (!m0_ack) begin
      errors++;
      $display("FAIL reset_reissue: m0_ack=%b required 1", m0_ack);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    clr_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    test_reset();
    test_single_read();
    test_tie();
    test_round_robin();
    test_timeout();
    test_drop_req();
    test_reset_mid();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
